bit_capture_bank: RTL and testbench

BIT_CAPTURE_BANK -- requirements
Module: bit_capture_bank

---
 rtl/bit_capture_pkg.sv | 13 +
 rtl/bit_capture_sync.sv | 26 ++
 rtl/bit_capture_bank.sv | 115 +++++++++++
 tb/tb_bit_capture_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_capture_pkg.sv
// rtl/bit_capture_pkg.sv - shared defaults and helpers for the bit capture bank
package bit_capture_pkg;

    localparam int CH_DEF   = 4;
    localparam int W_DEF    = 2;
    localparam int SYNC_DEF = 2;

    // Phase counter width: a 1-bit counter still exists when W=1.
    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_capture_sync.sv
// rtl/bit_capture_sync.sv - SYNC-stage flop chain bringing one asynchronous bit into CLK
module bit_capture_sync #(
    parameter int SYNC = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [SYNC-1:0] stg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stg <= '0;
        end else begin
            stg[0] <= d;
            for (int k = 1; k < SYNC; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    assign q = stg[SYNC-1];

endmodule

// File: rtl/bit_capture_bank.sv
// rtl/bit_capture_bank.sv - per-channel serial capture into W-bit snapshots with valid/ready output
// Optional change-detect flags are built only when BIT_CAPTURE_BANK_CHG_EN is defined.
module bit_capture_bank
    import bit_capture_pkg::*;
#(
    parameter int CH   = CH_DEF,
    parameter int W    = W_DEF,
    parameter int SYNC = SYNC_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CH-1:0]   IN,
    input  logic [CH-1:0]   EN,
    output logic            CAP_VALID,
    input  logic            CAP_READY,
    output logic [CH*W-1:0] CAP_DATA,
    output logic [CH-1:0]   CHG,
    output logic            OVF
);

    localparam int PW = cnt_w(W);

    logic [CH-1:0]   s;
    logic [W-1:0]    sr     [CH];
    logic [W-1:0]    sr_nxt [CH];
    logic [CH*W-1:0] snap_data;
    logic [PW-1:0]   phase;
    logic            en_any;
    logic            last;
    logic            snap;
    logic            hs;

    for (genvar g = 0; g < CH; g++) begin : g_sync
        bit_capture_sync #(.SYNC(SYNC)) u_sync (
            .CLK (CLK),
            .RST (RST),
            .d   (IN[g]),
            .q   (s[g])
        );
    end

    // Widen by one bit and keep the low W bits so W=1 needs no special case.
    always_comb begin
        logic [W:0] ext;
        ext       = '0;
        snap_data = '0;
        for (int i = 0; i < CH; i++) begin
            ext       = {sr[i], s[i]};
            sr_nxt[i] = EN[i] ? ext[W-1:0] : sr[i];
            snap_data[i*W +: W] = sr_nxt[i];
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < CH; i++) begin
            if (RST) begin
                sr[i] <= '0;
            end else begin
                sr[i] <= sr_nxt[i];
            end
        end
    end

    assign en_any = |EN;
    assign last   = (phase == PW'(W - 1));
    assign snap   = en_any && last;
    assign hs     = CAP_VALID && CAP_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= '0;
        end else if (en_any) begin
            phase <= last ? '0 : phase + 1'b1;
        end
    end

    // A snapshot replaces the held one if the slot is empty or being drained this cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CAP_DATA  <= '0;
            CAP_VALID <= 1'b0;
            OVF       <= 1'b0;
        end else if (snap) begin
            if (!CAP_VALID || CAP_READY) begin
                CAP_DATA  <= snap_data;
                CAP_VALID <= 1'b1;
            end else begin
                OVF <= 1'b1;
            end
        end else if (hs) begin
            CAP_VALID <= 1'b0;
        end
    end

`ifdef BIT_CAPTURE_BANK_CHG_EN
    logic [CH-1:0] s_prev;
    logic [CH-1:0] chg_r;

    // A fresh edge in the same cycle as a handshake survives the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s_prev <= '0;
            chg_r  <= '0;
        end else begin
            s_prev <= s;
            chg_r  <= (hs ? '0 : chg_r) | (EN & (s ^ s_prev));
        end
    end

    assign CHG = chg_r;
`else
    assign CHG = '0;
`endif

endmodule

// File: tb/tb_bit_capture_bank.sv
// tb/tb_bit_capture_bank.sv - randomized and directed checks of bit_capture_bank against a reference model
module tb_bit_capture_bank;

    localparam int CH   = 4;
    localparam int W    = 2;
    localparam int SYNC = 2;

    logic            CLK;
    logic            RST;
    logic [CH-1:0]   IN;
    logic [CH-1:0]   EN;
    logic            CAP_VALID;
    logic            CAP_READY;
    logic [CH*W-1:0] CAP_DATA;
    logic [CH-1:0]   CHG;
    logic            OVF;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 0;

    bit_capture_bank #(.CH(CH), .W(W), .SYNC(SYNC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN        (IN),
        .EN        (EN),
        .CAP_VALID (CAP_VALID),
        .CAP_READY (CAP_READY),
        .CAP_DATA  (CAP_DATA),
        .CHG       (CHG),
        .OVF       (OVF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: input history, integer shift values, snapshot slot.
    bit [CH-1:0]     m_hist [SYNC];
    int              m_sr   [CH];
    int              m_phase;
    bit              m_valid;
    logic [CH*W-1:0] m_data;
    bit              m_ovf;
    bit [CH-1:0]     m_chg;
    bit [CH-1:0]     m_prev;
    bit [CH-1:0]     m_sb;
    bit              m_hs;
    bit              m_snap;
    logic [CH*W-1:0] m_new;

    always @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
            for (int i = 0; i < CH; i++) m_sr[i] = 0;
            m_phase = 0;
            m_valid = 0;
            m_data  = '0;
            m_ovf   = 0;
            m_chg   = '0;
            m_prev  = '0;
        end else begin
            m_sb   = m_hist[SYNC-1];
            m_hs   = m_valid && CAP_READY;
            m_snap = (EN != 0) && (m_phase == W - 1);
`ifdef BIT_CAPTURE_BANK_CHG_EN
            if (m_hs) m_chg = '0;
            for (int i = 0; i < CH; i++)
                if (EN[i] && (m_sb[i] != m_prev[i])) m_chg[i] = 1'b1;
`endif
            m_prev = m_sb;
            for (int i = 0; i < CH; i++)
                if (EN[i]) m_sr[i] = (m_sr[i] * 2 + m_sb[i]) % (1 << W);
            if (EN != 0) m_phase = (m_phase + 1) % W;
            if (m_snap) begin
                m_new = '0;
                for (int i = 0; i < CH; i++) m_new = m_new | ((CH*W)'(m_sr[i]) << (i * W));
                if (!m_valid || CAP_READY) begin
                    m_data  = m_new;
                    m_valid = 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (m_hs) begin
                m_valid = 0;
            end
            for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = IN;
        end
    end

    always @(negedge CLK) begin
        if (mon_on) begin
            check("valid", CAP_VALID, m_valid);
            check("data",  CAP_DATA,  m_data);
            check("ovf",   OVF,       m_ovf);
            check("chg",   CHG,       m_chg);
        end
    end

    task automatic apply_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input logic [CH*W-1:0] want, input bit use_want);
        bit found;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge CLK);
            if (CAP_VALID && (!use_want || CAP_DATA == want)) found = 1;
        end
        check(tag, found, 1'b1);
    endtask

    logic [CH-1:0] chg_exp;

    initial begin
        RST       = 1'b1;
        IN        = 4'hF;
        EN        = 4'hF;
        CAP_READY = 1'b0;
        mon_on    = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("rst_valid", CAP_VALID, 1'b0);
            check("rst_data",  CAP_DATA,  8'h00);
            check("rst_chg",   CHG,       4'h0);
            check("rst_ovf",   OVF,       1'b0);
        end

        // Basic capture, one-cycle valid pulses every 2 cycles
        RST = 1'b0; IN = 4'b1010; CAP_READY = 1'b1;
        wait_valid("basic_found", 8'hCC, 1);
        check("basic_data", CAP_DATA, 8'hCC);
        @(negedge CLK);
        check("basic_pulse", CAP_VALID, 1'b0);
        @(negedge CLK);
        check("basic_next", CAP_VALID, 1'b1);

        // Backpressure across further snapshots
        CAP_READY = 1'b0; IN = 4'b0101;
        repeat (3) @(negedge CLK);
        check("bp_hold", CAP_DATA, 8'hCC);
        check("bp_ovf",  OVF,      1'b1);
        CAP_READY = 1'b1;
        repeat (2) @(negedge CLK);
        check("bp_ovf_sticky", OVF, 1'b1);

        // Snapshot coinciding with a handshake
        apply_reset();
        IN = 4'b0110; EN = 4'hF; CAP_READY = 1'b0;
        wait_valid("sim_first", '0, 0);
        @(negedge CLK);
        CAP_READY = 1'b1;
        @(negedge CLK);
        check("sim_valid", CAP_VALID, 1'b1);
        check("sim_data",  CAP_DATA,  8'h3C);
        check("sim_ovf",   OVF,       1'b0);

        // Channel mask
        apply_reset();
        IN = 4'hF; EN = 4'b0001; CAP_READY = 1'b1;
        repeat (5) @(negedge CLK);
        wait_valid("mask_found", 8'h03, 1);
        check("mask_data", CAP_DATA, 8'h03);

        // Change detect on channel 2
        apply_reset();
        IN = 4'h0; EN = 4'hF; CAP_READY = 1'b0;
        repeat (4) @(negedge CLK);
        IN = 4'b0100;
        repeat (6) @(negedge CLK);
`ifdef BIT_CAPTURE_BANK_CHG_EN
        chg_exp = 4'b0100;
`else
        chg_exp = 4'b0000;
`endif
        check("chg_set", CHG, chg_exp);
        CAP_READY = 1'b1;
        @(negedge CLK);
        check("chg_clear", CHG, 4'h0);

        // Randomized traffic with occasional resets
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            IN        = CH'($urandom);
            EN        = ($urandom_range(0, 3) == 0) ? CH'($urandom) : {CH{1'b1}};
            CAP_READY = ($urandom_range(0, 2) != 0);
            RST       = ($urandom_range(0, 299) == 0);
            @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
